// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - seven-segment bus monitor: decodes a multiplexed display back to a 16-bit BCD frame
// Optional SSEG_DEC_SYNC_EN adds a 2-flop input synchroniser ahead of the sample stage.
module sseg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_anode,
    input  logic [7:0]  i_sseg,
    output logic [15:0] o_value,
    output logic [3:0]  o_dp,
    output logic        o_valid,
    output logic        o_seg_err,
    output logic        o_an_err
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_HOLD} state_t;

    logic [3:0] w_an_in;
    logic [7:0] w_seg_in;

`ifdef SSEG_DEC_SYNC_EN
    logic [3:0] r_sync_an1, r_sync_an2;
    logic [7:0] r_sync_seg1, r_sync_seg2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_an1  <= '1;
            r_sync_an2  <= '1;
            r_sync_seg1 <= '1;
            r_sync_seg2 <= '1;
        end else begin
            r_sync_an1  <= i_anode;
            r_sync_an2  <= r_sync_an1;
            r_sync_seg1 <= i_sseg;
            r_sync_seg2 <= r_sync_seg1;
        end
    end

    assign w_an_in  = r_sync_an2;
    assign w_seg_in = r_sync_seg2;
`else
    assign w_an_in  = i_anode;
    assign w_seg_in = i_sseg;
`endif

    logic [3:0]      r_samp_an;
    logic [7:0]      r_samp_seg;
    logic [CW-1:0]   r_cnt;
    logic            r_accepted;
    state_t          r_state, w_state_next;
    logic [3:0][3:0] r_digit;
    logic [3:0]      r_dpbuf;
    logic [3:0]      r_seen;

    logic            w_change;
    logic            w_accept;
    logic [3:0]      w_low;
    logic            w_one_low;
    logic [1:0]      w_idx;
    logic            w_legal;
    logic [3:0]      w_code;
    logic [3:0][3:0] w_frame;
    logic [3:0]      w_dp_frame;

    // The counter tracks how many times the incoming sample has repeated the held one.
    assign w_change = {w_an_in, w_seg_in} != {r_samp_an, r_samp_seg};

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (w_change) begin
            w_state_next = (w_an_in == 4'hF) ? ST_BLANK : ST_SETTLE;
        end else if (r_state == ST_SETTLE && !r_accepted && r_cnt == CNT_ACC) begin
            w_accept     = 1'b1;
            w_state_next = ST_HOLD;
        end
    end

    assign w_low     = ~r_samp_an;
    assign w_one_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

    always_comb begin
        w_idx = 2'd0;
        case (w_low)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_legal = 1'b1;
        w_code  = 4'd0;
        case (r_samp_seg[6:0])
            7'h40: w_code = 4'd0;
            7'h79: w_code = 4'd1;
            7'h24: w_code = 4'd2;
            7'h30: w_code = 4'd3;
            7'h19: w_code = 4'd4;
            7'h12: w_code = 4'd5;
            7'h02: w_code = 4'd6;
            7'h78: w_code = 4'd7;
            7'h00: w_code = 4'd8;
            7'h10: w_code = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    // Frame as it will look including the digit being accepted this edge.
    always_comb begin
        w_frame    = r_digit;
        w_dp_frame = r_dpbuf;
        w_frame[w_idx]    = w_code;
        w_dp_frame[w_idx] = ~r_samp_seg[7];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_samp_an  <= '1;
            r_samp_seg <= '1;
            r_cnt      <= '0;
            r_accepted <= 1'b0;
            r_digit    <= '0;
            r_dpbuf    <= '0;
            r_seen     <= '0;
            o_value    <= '0;
            o_dp       <= '0;
            o_valid    <= 1'b0;
            o_seg_err  <= 1'b0;
            o_an_err   <= 1'b0;
        end else begin
            r_samp_an  <= w_an_in;
            r_samp_seg <= w_seg_in;
            o_valid    <= 1'b0;
            o_seg_err  <= 1'b0;
            o_an_err   <= 1'b0;

            if (w_change) begin
                r_cnt      <= '0;
                r_accepted <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_accepted <= 1'b1;
                end
            end

            if (w_accept) begin
                if (!w_one_low) begin
                    o_an_err <= 1'b1;
                    r_seen   <= '0;
                end else if (!w_legal) begin
                    o_seg_err <= 1'b1;
                    r_seen    <= '0;
                end else begin
                    r_digit <= w_frame;
                    r_dpbuf <= w_dp_frame;
                    if ((r_seen | w_low) == 4'hF) begin
                        o_value <= w_frame;
                        o_dp    <= w_dp_frame;
                        o_valid <= 1'b1;
                        r_seen  <= '0;
                    end else begin
                        r_seen <= r_seen | w_low;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_decoder.sv
// tb/tb_sseg_decoder.sv - directed self-checking bench for sseg_decoder
module tb_sseg_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode;
    logic [7:0]  sseg;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid, seg_err, an_err;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_seg = 0, n_an = 0;
    int b_valid, b_seg, b_an;

    sseg_decoder #(.STABLE_CYCLES(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_anode   (anode),
        .i_sseg    (sseg),
        .o_value   (value),
        .o_dp      (dp),
        .o_valid   (valid),
        .o_seg_err (seg_err),
        .o_an_err  (an_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid)   n_valid++;
        if (seg_err) n_seg++;
        if (an_err)  n_an++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] sg, input int n);
        anode = an;
        sseg  = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int i, input logic [3:0] d, input logic dp_on, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << i);
        show(an, {~dp_on, seg_of(d)}, n);
    endtask

    task automatic frame(input logic [15:0] v, input logic [3:0] dpm);
        for (int i = 0; i < 4; i++) digit(i, v[i*4 +: 4], dpm[i], 8);
        show(4'hF, 8'hFF, 4);
    endtask

    task automatic snap;
        b_valid = n_valid;
        b_seg   = n_seg;
        b_an    = n_an;
    endtask

    initial begin
        rst   = 1'b1;
        anode = 4'hF;
        sseg  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_seg_err", 32'(seg_err), 32'h0);
        chk("rst_an_err", 32'(an_err), 32'h0);
        rst = 1'b0;
        show(4'hF, 8'hFF, 4);

        snap();
        frame(16'h1234, 4'h0);
        chk("f1234_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("f1234_value", 32'(value), 32'h1234);
        chk("f1234_dp", 32'(dp), 32'h0);
        chk("f1234_errs", 32'(n_seg - b_seg + n_an - b_an), 32'd0);

        snap();
        digit(0, 4'd8, 1'b0, 8);
        digit(1, 4'd7, 1'b0, 8);
        digit(2, 4'd6, 1'b0, 8);
        show(4'b1110, 8'hFF, 8);
        show(4'hF, 8'hFF, 4);
        digit(3, 4'd5, 1'b0, 8);
        show(4'hF, 8'hFF, 4);
        chk("segerr_cnt", 32'(n_seg - b_seg), 32'd1);
        chk("segerr_no_valid", 32'(n_valid - b_valid), 32'd0);
        chk("segerr_value_kept", 32'(value), 32'h1234);

        snap();
        frame(16'h5678, 4'h0);
        chk("f5678_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("f5678_value", 32'(value), 32'h5678);

        snap();
        show(4'b1100, 8'hC0, 8);
        show(4'hF, 8'hFF, 4);
        chk("anerr_cnt", 32'(n_an - b_an), 32'd1);
        chk("anerr_no_valid", 32'(n_valid - b_valid), 32'd0);
        chk("anerr_value_kept", 32'(value), 32'h5678);

        snap();
        digit(0, 4'd5, 1'b0, 8);
        digit(1, 4'd7, 1'b0, 8);
        digit(2, 4'd9, 1'b0, 8);
        show(4'b1011, 8'h80, 3);
        digit(3, 4'd0, 1'b0, 8);
        show(4'hF, 8'hFF, 4);
        chk("glitch_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("glitch_value", 32'(value), 32'h0975);
        chk("glitch_errs", 32'(n_seg - b_seg + n_an - b_an), 32'd0);

        snap();
        frame(16'h4321, 4'b0010);
        chk("dp_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("dp_value", 32'(value), 32'h4321);
        chk("dp_mask", 32'(dp), 32'h2);

        digit(0, 4'd8, 1'b0, 8);
        digit(1, 4'd8, 1'b0, 8);
        digit(2, 4'd8, 1'b0, 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_value", 32'(value), 32'h0);
        snap();
        digit(3, 4'd8, 1'b0, 8);
        show(4'hF, 8'hFF, 4);
        chk("midrst_no_valid", 32'(n_valid - b_valid), 32'd0);
        frame(16'h8888, 4'h0);
        chk("f8888_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("f8888_value", 32'(value), 32'h8888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sseg_decoder.md
# sseg_decoder

Receive-side counterpart of the multiplexed seven-segment display driver: it watches the time-multiplexed anode/segment bus, decodes each stable digit back to BCD, and reassembles the full 16-bit value. It sits in the loopback/self-check path, monitoring the display outputs so the stopwatch can be verified end-to-end on the bench or in-system. It is a monitor only and never drives the display bus.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples (≥2) required before a digit is accepted
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- anode  input  4  display anodes, active-low; anode[0] = BCD0 (least-significant digit) … anode[3] = BCD3
- sseg  input  8  segment lines, active-low; sseg[6:0] = {g,f,e,d,c,b,a}, sseg[7] = dp
- value  output  16  last complete frame, {BCD3,BCD2,BCD1,BCD0}
- dp  output  4  decimal-point state per digit for the last frame, active-high
- valid  output  1  one-cycle pulse when value/dp update
- seg_err  output  1  one-cycle pulse: stable segment pattern is not a legal digit
- an_err  output  1  one-cycle pulse: stable anode has more than one line low

## Operation
- Sample stage: anode and sseg are registered each clk to form sample S; previous sample P is also held.
- Stability counter cnt (width clog2(STABLE_CYCLES)+1): cnt←0 when S≠P, else increments, saturating at STABLE_CYCLES. An `accepted` flag is cleared whenever S≠P.
- Acceptance happens on the edge where cnt reaches STABLE_CYCLES−1→STABLE_CYCLES with `accepted`=0; `accepted` then sets, so each stable period is acted on exactly once.
- FSM states: BLANK (all anodes high), SETTLE (counting), HOLD (accepted, waiting for a change). Any S≠P returns to SETTLE, or to BLANK if anode = 4'b1111. BLANK never accepts.
- On acceptance with exactly one anode low at index i:
  - legal pattern (sseg[6:0] active-low: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10): digit[i]←code, dpbuf[i]←~sseg[7], seen[i]←1; re-capture of an already-seen digit overwrites it.
  - illegal pattern: seg_err pulses, seen←0, nothing written.
- On acceptance with ≥2 anodes low: an_err pulses, seen←0.
- Frame completion: if acceptance makes seen = 4'b1111, then on the same edge value←{digit3..0} including the new digit, dp←dpbuf, valid pulses, and seen←0.
- Simultaneous events are exclusive by construction; only one acceptance occurs per edge.

## Timing
- Reset values: value=16'h0000, dp=4'h0, valid=0, seg_err=0, an_err=0, seen=0, cnt=0, accepted=0, FSM=BLANK, sample registers all-ones (blank).
- Latency, input change to acceptance edge: 1 (sample) + STABLE_CYCLES clocks, plus 2 when synchroniser enabled.
- Glitches shorter than STABLE_CYCLES samples are ignored entirely.
- Reset mid-frame discards partial digits; the first valid after reset requires all four digits to be freshly accepted.
- valid/seg_err/an_err are registered, high for exactly one clk.

## Configuration
- SSEG_DEC_SYNC_EN defined: anode and sseg pass through a 2-flop synchroniser (reset to all-ones) ahead of the sample stage; latency +2 clocks. Use when the bus comes from another clock domain or pins.
- Undefined: inputs go straight into the sample stage (same-clock loopback only).

## Test plan
- Drive a 1234 display cycle (each digit held 8 clocks, order 0→3) -> exactly one valid per complete cycle, value=16'h1234, dp=4'h0.
- anode=4'b1110, sseg=8'hFF (blank/illegal) held 8 clocks -> single seg_err pulse, seen cleared, no valid; next full cycle of 5678 -> value=16'h5678.
- anode=4'b1100 held 8 clocks -> single an_err pulse, no capture; value unchanged.
- Insert a 3-clock glitch (STABLE_CYCLES=4) of pattern 0x00 on digit 2 during a 0975 cycle -> no error, value=16'h0975.
- Digit 1 shown with sseg[7]=0 during a 4321 cycle -> value=16'h4321, dp=4'b0010.
- Assert rst after digits 0–2 accepted, release, show digit 3 only -> no valid; following full 8888 cycle -> value=16'h8888, valid once.
